// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, single-outstanding fetch to the
// instruction port, and a registered IF/ID slot backed by a one-entry skid buffer.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | dead cycle after reset release, no request
// S_REQ  | inst_req high, waiting for inst_addr_ok
// S_WAIT | request accepted, waiting for inst_data_ok
// S_FULL | ID slot stalled, returned word parked in skid buffer
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_FULL = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        discard;
    logic [31:0] sk_inst;
    logic [31:0] sk_pc;
    logic        consume;
    logic [31:0] redirect_tgt;

    assign consume      = id_valid & ~id_stall;
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign inst_req     = (state == S_REQ);
    assign inst_addr    = {pc[31:2], 2'b00};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            req_pc   <= 32'd0;
            discard  <= 1'b0;
            sk_inst  <= 32'd0;
            sk_pc    <= 32'd0;
            id_valid <= 1'b0;
            id_inst  <= 32'd0;
            id_pc    <= 32'd0;
        end else begin
            // A consumed slot drains unless a new word is loaded below.
            if (consume) begin
                id_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    state <= S_REQ;
                end
                S_REQ: begin
                    if (inst_addr_ok) begin
                        req_pc <= pc;
                        pc     <= pc + 32'd4;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= S_REQ;
                        end else if (!id_valid || consume) begin
                            id_valid <= 1'b1;
                            id_inst  <= inst_rdata;
                            id_pc    <= req_pc;
                            state    <= S_REQ;
                        end else begin
                            sk_inst <= inst_rdata;
                            sk_pc   <= req_pc;
                            state   <= S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (consume) begin
                        id_valid <= 1'b1;
                        id_inst  <= sk_inst;
                        id_pc    <= sk_pc;
                        state    <= S_REQ;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Taken branch/jump kills every younger instruction, in flight or parked.
            if (redirect) begin
                pc       <= redirect_tgt;
                id_valid <= 1'b0;
                case (state)
                    S_REQ: begin
                        if (inst_addr_ok) begin
                            discard <= 1'b1;
                            state   <= S_WAIT;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                    S_WAIT: begin
                        if (inst_data_ok) begin
                            discard <= 1'b0;
                            state   <= S_REQ;
                        end else begin
                            discard <= 1'b1;
                        end
                    end
                    S_FULL: begin
                        state <= S_REQ;
                    end
                    default: begin
                        state <= S_REQ;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random memory/stall/redirect
// traffic checked against an architectural program-order model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic [31:0] inst_rdata = 32'd0;
    logic        inst_data_ok = 1'b0;
    logic        id_stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_rdata  (inst_rdata),
        .inst_data_ok(inst_data_ok),
        .id_stall    (id_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus knobs
    int          p_addr = 100;
    int          p_stall = 0;
    int          p_redir = 0;
    int          dmin = 0;
    int          dmax = 0;
    bit          force_redir = 1'b0;
    logic [31:0] force_tgt = 32'd0;

    // memory and program-order model
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    int          pend_dly = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] acc_q[$];
    bit          last_unacc = 1'b0;
    logic [31:0] last_addr = 32'd0;

    // outputs sampled before the edge and inputs applied at it
    bit          s_req, s_idv;
    logic [31:0] s_addr, s_inst, s_pc;
    bit          d_aok, d_dok, d_stall, d_redir, d_consume;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        case (a)
            RESET_PC:          return 32'h2408_0001;
            RESET_PC + 32'd4:  return 32'h2409_0002;
            RESET_PC + 32'd8:  return 32'h0109_5020;
            default:           return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    task automatic drive();
        logic [31:0] tgt;
        s_req  = inst_req;
        s_addr = inst_addr;
        s_idv  = id_valid;
        s_inst = id_inst;
        s_pc   = id_pc;
        if (s_req) begin
            chk("addr_align", {30'd0, s_addr[1:0]}, 32'd0);
            chk("one_outstanding", {31'd0, pend}, 32'd0);
            if (last_unacc) chk("addr_stable", s_addr, last_addr);
        end
        d_aok = s_req && ($urandom_range(99) < p_addr);
        d_dok = 1'b0;
        inst_rdata = $urandom();
        if (pend) begin
            if (pend_dly == 0) begin
                d_dok = 1'b1;
                inst_rdata = memword(pend_addr);
            end else begin
                pend_dly--;
            end
        end
        d_stall   = ($urandom_range(99) < p_stall);
        d_consume = s_idv && !d_stall;
        d_redir   = 1'b0;
        tgt       = 32'd0;
        if (d_consume) begin
            chk("id_pc", s_pc, exp_pc);
            chk("id_inst", s_inst, memword(exp_pc));
            if (force_redir || ($urandom_range(99) < p_redir)) begin
                d_redir = 1'b1;
                if (force_redir) tgt = force_tgt;
                else if ($urandom_range(7) == 0) tgt = 32'hFFFF_FFFC;
                else tgt = $urandom();
                force_redir = 1'b0;
                exp_pc = tgt & 32'hFFFF_FFFC;
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
        end
        inst_addr_ok = d_aok;
        inst_data_ok = d_dok;
        id_stall     = d_stall;
        redirect     = d_redir;
        redirect_pc  = d_redir ? tgt : $urandom();
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (d_dok) pend = 1'b0;
        if (d_aok) begin
            pend      = 1'b1;
            pend_addr = s_addr;
            pend_dly  = $urandom_range(dmax, dmin);
            acc_q.push_back(s_addr);
        end
        last_unacc = s_req && !d_aok && !d_redir;
        last_addr  = s_addr;
        if (d_redir) begin
            chk("kill_after_redirect", {31'd0, id_valid}, 32'd0);
        end else if (s_idv && d_stall) begin
            chk("hold_valid", {31'd0, id_valid}, 32'd1);
            chk("hold_inst", id_inst, s_inst);
            chk("hold_pc", id_pc, s_pc);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive();
            tick();
        end
    endtask

    task automatic wait_pc(input logic [31:0] pc, input string tag);
        bit found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            drive();
            tick();
            found = id_valid && (id_pc == pc);
        end
        chk(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic clear_model();
        pend = 1'b0;
        exp_pc = RESET_PC;
        last_unacc = 1'b0;
        force_redir = 1'b0;
        d_aok = 1'b0; d_dok = 1'b0; d_stall = 1'b0; d_redir = 1'b0; d_consume = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; id_stall = 1'b0; redirect = 1'b0;
        acc_q.delete();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, inst_req}, 32'd0);
        chk("rst_addr", inst_addr, RESET_PC);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_inst", id_inst, 32'd0);
        resetn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // best-case streaming after reset
        p_addr = 100; dmin = 0; dmax = 0; p_stall = 0; p_redir = 0;
        do_reset();
        drive(); tick();
        chk("first_req", {31'd0, inst_req}, 32'd1);
        chk("first_addr", inst_addr, RESET_PC);
        for (int i = 0; i < 6; i++) begin
            drive(); tick();
            chk("t1_valid", {31'd0, id_valid}, i % 2);
            if (i % 2 == 1) chk("t1_pc", id_pc, RESET_PC + 32'(4 * (i / 2)));
        end

        // stall parks the next word in the skid buffer
        p_stall = 100;
        for (int i = 0; i < 5; i++) begin
            drive(); tick();
            chk("skid_no_req", {31'd0, inst_req}, 32'd0);
        end
        p_stall = 0;
        drive(); tick();
        chk("skid_valid", {31'd0, id_valid}, 32'd1);
        chk("skid_pc", id_pc, RESET_PC + 32'd12);
        chk("skid_resume_req", {31'd0, inst_req}, 32'd1);
        chk("skid_resume_addr", inst_addr, RESET_PC + 32'd16);
        run(6);

        // redirect with a fetch outstanding
        dmin = 1; dmax = 1;
        do_reset();
        wait_pc(RESET_PC + 32'd4, "t3_reach");
        p_stall = 100;
        drive(); tick();
        p_stall = 0;
        force_redir = 1'b1; force_tgt = 32'h8000_0103;
        drive(); tick();
        chk("t3_addr", inst_addr, 32'h8000_0100);
        chk("t3_noreq", {31'd0, inst_req}, 32'd0);
        drive(); tick();
        chk("t3_drop_valid", {31'd0, id_valid}, 32'd0);
        chk("t3_req", {31'd0, inst_req}, 32'd1);
        chk("t3_req_addr", inst_addr, 32'h8000_0100);
        wait_pc(32'h8000_0100, "t3_target");

        // redirect while the skid buffer is full
        dmin = 0; dmax = 0;
        do_reset();
        wait_pc(RESET_PC, "t4_reach");
        p_stall = 100;
        run(2);
        chk("t4_full_noreq", {31'd0, inst_req}, 32'd0);
        p_stall = 0;
        force_redir = 1'b1; force_tgt = 32'h0000_1230;
        drive(); tick();
        chk("t4_req", {31'd0, inst_req}, 32'd1);
        chk("t4_addr", inst_addr, 32'h0000_1230);
        wait_pc(32'h0000_1230, "t4_target");

        // wrap-around of the program counter
        force_redir = 1'b1; force_tgt = 32'hFFFF_FFFC;
        for (int k = 0; k < 50 && force_redir; k++) begin
            drive(); tick();
        end
        chk("t5_redir_taken", {31'd0, force_redir}, 32'd0);
        acc_q.delete();
        for (int k = 0; k < 50 && acc_q.size() < 2; k++) run(1);
        chk("t5_count", {31'd0, acc_q.size() >= 2}, 32'd1);
        if (acc_q.size() >= 2) begin
            chk("t5_first", acc_q[0], 32'hFFFF_FFFC);
            chk("t5_wrap", acc_q[1], 32'h0000_0000);
        end
        wait_pc(32'h0000_0000, "t5_wrap_id");

        // asynchronous reset mid-wait with a stale response
        dmin = 3; dmax = 3;
        do_reset();
        for (int k = 0; k < 20 && !pend; k++) run(1);
        chk("t6_in_wait", {31'd0, pend}, 32'd1);
        #2;
        resetn = 1'b0;
        clear_model();
        #1;
        chk("t6_rst_valid", {31'd0, id_valid}, 32'd0);
        chk("t6_rst_req", {31'd0, inst_req}, 32'd0);
        chk("t6_rst_addr", inst_addr, RESET_PC);
        inst_data_ok = 1'b1;
        inst_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t6_stale_valid", {31'd0, id_valid}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("t6_idle_valid", {31'd0, id_valid}, 32'd0);
        chk("t6_restart_req", {31'd0, inst_req}, 32'd1);
        chk("t6_restart_addr", inst_addr, RESET_PC);
        inst_data_ok = 1'b0;
        dmin = 0; dmax = 2;
        wait_pc(RESET_PC, "t6_first");
        wait_pc(RESET_PC + 32'd4, "t6_second");

        // random traffic
        p_addr = 60; dmin = 0; dmax = 3; p_stall = 30; p_redir = 15;
        do_reset();
        run(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage: owns the program counter, issues one-outstanding-request fetches to the instruction memory port and delivers fetched words to decode through a registered IF/ID slot backed by a one-entry skid buffer. It sits directly upstream of the main decoder: `id_inst[31:26]` drives the decoder's opcode input, and decode returns `id_stall` and branch/jump `redirect`. Architecture has no branch delay slot; a redirect kills every younger instruction.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: first fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `inst_req` out 1: fetch request valid.
- `inst_addr` out 32: fetch address, bits [1:0] always 00.
- `inst_addr_ok` in 1: request accepted this cycle.
- `inst_rdata` in 32: returned instruction word.
- `inst_data_ok` in 1: `inst_rdata` valid this cycle.
- `id_stall` in 1: decode cannot consume the ID slot this cycle.
- `redirect` in 1: branch/jump taken, 1-cycle pulse.
- `redirect_pc` in 32: target; bits [1:0] ignored.
- `id_valid` out 1: ID slot holds a valid instruction.
- `id_inst` out 32: instruction in ID slot.
- `id_pc` out 32: address of `id_inst`.

## Operation
- Registers: `pc`, `req_pc`, `discard`, skid {`sk_inst`, `sk_pc`}, ID slot {`id_valid`, `id_inst`, `id_pc`}, state.
- Reset values: state S_IDLE, `pc`=RESET_PC, `discard`=0, `id_valid`=0, `id_inst`=0, `id_pc`=0, skid=0; hence `inst_req`=0, `inst_addr`=RESET_PC.
- `inst_req` = (state==S_REQ); `inst_addr` = {pc[31:2],2'b00}. Both combinational from registers.
- Consume: `id_valid` & ~`id_stall`. `redirect` is only legal in a consume cycle; it means the ID-slot instruction was a taken branch/jump.
- States:
  - S_IDLE: -> S_REQ unconditionally (one dead cycle after reset release).
  - S_REQ: on `inst_addr_ok`: `req_pc`<=pc, pc<=pc+4, -> S_WAIT.
  - S_WAIT: on `inst_data_ok`: if `discard`, drop word, clear `discard`, -> S_REQ; else if ID slot free or consumed this cycle, load ID slot {rdata, req_pc}, -> S_REQ; else load skid, -> S_FULL.
  - S_FULL: when ID slot consumed, move skid into ID slot, -> S_REQ.
- Redirect (overrides normal updates, same cycle): pc<=redirect_pc&~3; `id_valid`<=0; skid dropped.
  - In S_REQ with `inst_addr_ok`: request already issued, set `discard`, -> S_WAIT.
  - In S_REQ without `inst_addr_ok`: stay S_REQ (new pc seen next cycle).
  - In S_WAIT: if `inst_data_ok` same cycle, drop word, -> S_REQ; else set `discard`, stay.
  - In S_FULL: -> S_REQ.
- `inst_data_ok` outside S_WAIT is ignored (stale response after reset).
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- ID slot holds its contents unchanged while `id_valid` & `id_stall`.

## Timing
- Best case: addr_ok at cycle t, data_ok at t+1, `id_valid`=1 at t+2; next `inst_req` at t+2. Peak throughput one instruction per 2 cycles.
- `inst_req` stays high, `inst_addr` stable, until `inst_addr_ok` (except pc change on redirect).
- Never more than one outstanding request.
- Reset assertion clears all state immediately, mid-request or mid-wait; no output glitch to a valid `id_valid`.
- First `inst_req` occurs 1 cycle after `resetn` rises (S_IDLE).

## Test plan
- Reset release, memory with addr_ok same cycle and data_ok 1 cycle later, words 0x2408_0001,0x2409_0002,0x0109_5020 -> first `inst_addr`=BFC0_0000 one cycle after reset; id_pc sequence BFC0_0000, BFC0_0004, BFC0_0008 each `id_valid` 1 cycle, 2-cycle spacing.
- `id_stall` held 5 cycles while next word returns -> word parked in skid, no new `inst_req`; on stall release ID shows skid word next cycle, then fetch resumes at pc+4, no loss or duplication.
- Redirect to 0x8000_0103 while a fetch for BFC0_0008 is outstanding -> returned word dropped, next `inst_addr`=8000_0100, `id_valid`=0 for the redirect-following cycle, next id_pc=8000_0100.
- Redirect in S_FULL -> skid word never reaches ID; next fetch at target.
- Redirect to FFFF_FFFC -> fetches FFFF_FFFC then 0000_0000.
- Assert `resetn` low while in S_WAIT, then deliver `inst_data_ok` during/after reset -> `id_valid` stays 0; fetch restarts at RESET_PC.
